write_master_arbiter: RTL
=========================

// Module: write_master_arbiter
// PURPOSE
//  - Shares one Avalon-MM burst write master (ctrl: fixed_location/write_base/lenght/go/done;
//    user: write_buffer/buffer_input_data/buffer_full) between NUM_REQ requesters.
//  - Round-robin grant; streams the winner's words into the master's user buffer; pulses go;
//    waits for done; reports completion per requester.
//  - Sits between the button/sensor capture blocks and the write master IP.
// PARAMETERS
//  NUM_REQ    2   number of requesters (>=2)
//  ADDR_W     32  byte address width
//  DATA_W     32  word width; byte length = words*(DATA_W/8)
//  LEN_W      8   word-count width per transfer
//  TIMEOUT_CYC 4096  WAIT_DONE watchdog limit (used only with WMA_TIMEOUT_EN)
// PORTS
//  clk                            in   1                system clock
//  reset                          in   1                synchronous, active-high
//  req                            in   NUM_REQ          per-requester transfer request (level)
//  req_addr                       in   NUM_REQ*ADDR_W   flat; slice i = start byte addr of i
//  req_len                        in   NUM_REQ*LEN_W    flat; slice i = word count of i
//  src_data                       in   NUM_REQ*DATA_W   flat; word stream of i
//  src_valid                      in   NUM_REQ          word of i valid
//  src_ready                      out  NUM_REQ          word of i accepted when valid&ready
//  grant                          out  NUM_REQ          one-hot owner, 0 when idle
//  xfer_done                      out  NUM_REQ          1-cycle pulse at end of i's transfer
//  err                            out  1                1-cycle pulse: zero-len or timeout
//  master_crtl_fixed_location     out  1                constant 0
//  master_crtl_write_base         out  ADDR_W           latched req_addr of owner
//  master_crtl_lenght             out  ADDR_W           latched req_len*(DATA_W/8), zero-extended
//  master_crtl_go                 out  1                1-cycle start pulse
//  master_crtl_done               in   1                master finished burst
//  master_user_write_buffer       out  1                push strobe into master buffer
//  master_user_buffer_input_data  out  DATA_W           pushed word
//  master_user_buffer_full        in   1                master buffer full
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, rr pointer = 0 (requester 0 highest priority).
//  - IDLE: if |req, pick first set bit at/after pointer; register grant, base, length,
//    word counter = req_len -> FILL next cycle (grant visible 1 cycle after req).
//  - req_len==0: no buffer writes, no go; err and xfer_done[i] pulse, -> RELEASE.
//  - FILL: src_ready[i] = grant[i] & ~buffer_full; on valid&ready: write_buffer=1 and
//    input_data=src_data slice, both combinational same cycle; counter-1; last word -> GO.
//    buffer_full stalls without losing data; non-granted src_ready always 0.
//  - GO: master_crtl_go=1 exactly one cycle, base/length stable from grant through done -> WAIT_DONE.
//  - WAIT_DONE: on master_crtl_done -> xfer_done[owner] pulse, -> RELEASE. done seen in any
//    other state is ignored.
//  - RELEASE: grant=0, pointer = owner+1 (wraps NUM_REQ-1 -> 0) -> IDLE; one idle cycle
//    between grants guaranteed.
//  - req deassert mid-transfer ignored; transfer completes. Reset mid-transfer aborts
//    immediately; master not signalled.
//  - Same requester re-asserting keeps fair rotation: others pending win first.
// CONFIGURATION
//  - `WMA_TIMEOUT_EN defined: cycle counter in WAIT_DONE; at TIMEOUT_CYC with no done ->
//    err pulse, no xfer_done, -> RELEASE. Undefined: WAIT_DONE waits indefinitely, no counter.
// STRUCTURE
//  - Package wma_pkg: state enum (IDLE,FILL,GO,WAIT_DONE,RELEASE), BYTES_PER_WORD constant.
//  - Sub-module rr_arbiter: req vector + pointer -> one-hot winner and index (combinational).
// TESTING
//  1 req=01, addr0=0x10000000, len0=4, words 13,14,15,16 -> 4 buffer pushes in order,
//    write_base=0x10000000, lenght=16, one go pulse, done -> xfer_done=01.
//  2 req=11 from reset -> grant 01 first, then 10; with req held at 11 grants alternate 01,10,01.
//  3 buffer_full held high 5 cycles mid-FILL -> no pushes, src_ready=0, all 4 words delivered after.
//  4 req0 len=0 -> err and xfer_done[0] pulse, no write_buffer, no go.
//  5 reset asserted in WAIT_DONE -> next cycle grant=0, go=0, state IDLE; stale done ignored.
//  6 `WMA_TIMEOUT_EN, TIMEOUT_CYC=16, done never -> err at cycle 16 of WAIT_DONE, grant released.

Source files
------------

// File: rtl/wma_pkg.sv
// Shared types and constants for the write-master arbiter.
// Holds the FSM state encoding and the word-to-byte conversion helpers.
package wma_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FILL      = 3'd1,
        GO        = 3'd2,
        WAIT_DONE = 3'd3,
        RELEASE   = 3'd4
    } state_t;

    localparam int WMA_DATA_W     = 32;
    localparam int BYTES_PER_WORD = WMA_DATA_W / 8;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/write_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping to the lowest index. Returns one-hot winner and its binary index.
module rr_arbiter
    import wma_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
)(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_mask;
    logic [NUM_REQ-1:0] w_hi;
    logic [NUM_REQ-1:0] w_pick;
    logic [IDX_W-1:0]   w_idx_chain [NUM_REQ+1];

    // Requests at/above the pointer win; otherwise wrap around to the full vector.
    assign w_mask  = ~((NUM_REQ'(1) << i_ptr) - NUM_REQ'(1));
    assign w_hi    = i_req & w_mask;
    assign w_pick  = (|w_hi) ? w_hi : i_req;
    assign o_grant = w_pick & (~w_pick + NUM_REQ'(1));
    assign o_any   = |i_req;

    assign w_idx_chain[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_enc
            assign w_idx_chain[gi+1] = w_idx_chain[gi] | (o_grant[gi] ? IDX_W'(gi) : '0);
        end
    endgenerate

    assign o_idx = w_idx_chain[NUM_REQ];

endmodule

// File: rtl/write_master_arbiter.sv
// Shares one Avalon-MM burst write master between NUM_REQ requesters (round-robin).
// Optional WAIT_DONE watchdog is compiled in when WMA_TIMEOUT_EN is defined.
module write_master_arbiter
    import wma_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = WMA_DATA_W,
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 4096
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] src_data,
    input  logic [NUM_REQ-1:0]        src_valid,
    output logic [NUM_REQ-1:0]        src_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        xfer_done,
    output logic                      err,
    output logic                      master_crtl_fixed_location,
    output logic [ADDR_W-1:0]         master_crtl_write_base,
    output logic [ADDR_W-1:0]         master_crtl_lenght,
    output logic                      master_crtl_go,
    input  logic                      master_crtl_done,
    output logic                      master_user_write_buffer,
    output logic [DATA_W-1:0]         master_user_buffer_input_data,
    input  logic                      master_user_buffer_full
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BPW   = bytes_per_word(DATA_W);

    state_t             r_state;
    state_t             w_state_next;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_xfer_done;
    logic               r_err;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  r_len_bytes;
    logic [LEN_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0] w_win_grant;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_any;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [LEN_W-1:0]   w_win_len;
    logic [DATA_W-1:0]  w_own_data;
    logic [NUM_REQ-1:0] w_src_ready;
    logic               w_fill_active;
    logic               w_push;
    logic               w_timeout;
    logic               w_load;
    logic               w_zero_len;
    logic               w_done_ok;
    logic               w_timed_out;

    logic [ADDR_W-1:0]  w_addr_chain [NUM_REQ+1];
    logic [LEN_W-1:0]   w_len_chain  [NUM_REQ+1];
    logic [DATA_W-1:0]  w_data_chain [NUM_REQ+1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_win_grant),
        .o_idx   (w_win_idx),
        .o_any   (w_win_any)
    );

    // One-hot AND-OR muxes: winner's request fields and current owner's word.
    assign w_addr_chain[0] = '0;
    assign w_len_chain[0]  = '0;
    assign w_data_chain[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign w_addr_chain[gi+1] = w_addr_chain[gi]
                | (w_win_grant[gi] ? req_addr[gi*ADDR_W +: ADDR_W] : '0);
            assign w_len_chain[gi+1]  = w_len_chain[gi]
                | (w_win_grant[gi] ? req_len[gi*LEN_W +: LEN_W] : '0);
            assign w_data_chain[gi+1] = w_data_chain[gi]
                | (r_grant[gi] ? src_data[gi*DATA_W +: DATA_W] : '0);
        end
    endgenerate

    assign w_win_addr = w_addr_chain[NUM_REQ];
    assign w_win_len  = w_len_chain[NUM_REQ];
    assign w_own_data = w_data_chain[NUM_REQ];

    assign w_fill_active = (r_state == FILL) && (r_cnt != '0) && !master_user_buffer_full;
    assign w_src_ready   = w_fill_active ? r_grant : '0;
    assign w_push        = |(src_valid & w_src_ready);

`ifdef WMA_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0] r_timer;

    always_ff @(posedge clk) begin
        if (reset || (r_state != WAIT_DONE)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    assign w_timeout = (r_state == WAIT_DONE) && (r_timer == TMR_W'(TIMEOUT_CYC - 1));
`else
    // Without the watchdog WAIT_DONE never gives up; the limit is never reached.
    assign w_timeout = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_zero_len   = 1'b0;
        w_done_ok    = 1'b0;
        w_timed_out  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_win_any) begin
                    w_load       = 1'b1;
                    w_state_next = FILL;
                end
            end
            FILL: begin
                if (r_cnt == '0) begin
                    w_zero_len   = 1'b1;
                    w_state_next = RELEASE;
                end else if (w_push && (r_cnt == LEN_W'(1))) begin
                    w_state_next = GO;
                end
            end
            GO: begin
                w_state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (master_crtl_done) begin
                    w_done_ok    = 1'b1;
                    w_state_next = RELEASE;
                end else if (w_timeout) begin
                    w_timed_out  = 1'b1;
                    w_state_next = RELEASE;
                end
            end
            RELEASE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_xfer_done <= '0;
            r_err       <= 1'b0;
            r_owner     <= '0;
            r_ptr       <= '0;
            r_base      <= '0;
            r_len_bytes <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_next;
            r_xfer_done <= '0;
            r_err       <= 1'b0;
            if (w_load) begin
                r_grant     <= w_win_grant;
                r_owner     <= w_win_idx;
                r_base      <= w_win_addr;
                r_len_bytes <= ADDR_W'(w_win_len) * ADDR_W'(BPW);
                r_cnt       <= w_win_len;
            end
            if (w_push) begin
                r_cnt <= r_cnt - LEN_W'(1);
            end
            if (w_zero_len) begin
                r_err       <= 1'b1;
                r_xfer_done <= r_grant;
                r_grant     <= '0;
            end
            if (w_done_ok) begin
                r_xfer_done <= r_grant;
                r_grant     <= '0;
            end
            if (w_timed_out) begin
                r_err   <= 1'b1;
                r_grant <= '0;
            end
            // Rotate past the owner so any other pending requester wins next.
            if (r_state == RELEASE) begin
                r_ptr <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
            end
        end
    end

    assign src_ready                     = w_src_ready;
    assign grant                         = r_grant;
    assign xfer_done                     = r_xfer_done;
    assign err                           = r_err;
    assign master_crtl_fixed_location    = 1'b0;
    assign master_crtl_write_base        = r_base;
    assign master_crtl_lenght            = r_len_bytes;
    assign master_crtl_go                = (r_state == GO);
    assign master_user_write_buffer      = w_push;
    assign master_user_buffer_input_data = w_push ? w_own_data : '0;

endmodule
